// File: rtl/regfile_sb_if.sv
// Bundles the read, write-back, issue and debug signals of the integer register file.
// The slave modport is the register file and the master modport is the core side.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
);
    logic             ready;
    logic [AW-1:0]    rs1_addr;
    logic [AW-1:0]    rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic             issue_en;
    logic [AW-1:0]    issue_rd;
    logic [AW-1:0]    dbg_addr;
    logic [XLEN-1:0]  dbg_data;
    logic [NREGS-1:0] busy_vec;

    modport slave (
        output ready, rs1_data, rs2_data, rs1_busy, rs2_busy, dbg_data, busy_vec,
        input  rs1_addr, rs2_addr, wb_en, wb_addr, wb_data, issue_en, issue_rd, dbg_addr
    );

    modport master (
        input  ready, rs1_data, rs2_data, rs1_busy, rs2_busy, dbg_data, busy_vec,
        output rs1_addr, rs2_addr, wb_en, wb_addr, wb_data, issue_en, issue_rd, dbg_addr
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with a pending-write scoreboard, two combinational read ports and optional bypass.
// After reset it zeroes one entry per cycle, then reports ready.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input logic          clk,
    input logic          rst,
    regfile_sb_if.slave  bus
);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    clr_idx_q, clr_idx_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic             run;
    logic             wb_ok;
    logic             issue_ok;

    assign run      = (state_q == ST_RUN);
    assign wb_ok    = run && bus.wb_en && (bus.wb_addr != '0);
    assign issue_ok = run && bus.issue_en && (bus.issue_rd != '0);

    // Clear sequence ends on the edge that writes the last entry, so the index never wraps.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            if (clr_idx_q == AW'(NREGS - 1)) begin
                state_d = ST_RUN;
            end else begin
                clr_idx_d = clr_idx_q + AW'(1);
            end
        end
    end

    // Issue is applied after write-back so the newer producer keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wb_ok) begin
            busy_d[bus.wb_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= AW'(1);
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // Storage has no reset; entry 0 is never written and is masked on every read path.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else if (wb_ok) begin
            mem_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        bus.rs1_data = '0;
        bus.rs1_busy = 1'b0;
        if (run && (bus.rs1_addr != '0)) begin
            if ((BYPASS != 0) && wb_ok && (bus.wb_addr == bus.rs1_addr)) begin
                bus.rs1_data = bus.wb_data;
            end else begin
                bus.rs1_data = mem_q[bus.rs1_addr];
                bus.rs1_busy = busy_q[bus.rs1_addr];
            end
        end
    end

    always_comb begin
        bus.rs2_data = '0;
        bus.rs2_busy = 1'b0;
        if (run && (bus.rs2_addr != '0)) begin
            if ((BYPASS != 0) && wb_ok && (bus.wb_addr == bus.rs2_addr)) begin
                bus.rs2_data = bus.wb_data;
            end else begin
                bus.rs2_data = mem_q[bus.rs2_addr];
                bus.rs2_busy = busy_q[bus.rs2_addr];
            end
        end
    end

    assign bus.dbg_data = (run && (bus.dbg_addr != '0)) ? mem_q[bus.dbg_addr] : '0;
    assign bus.busy_vec = busy_q;
    assign bus.ready    = run;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing instance and one non-bypassing instance share stimulus.
module tb_regfile_sb;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    regfile_sb_if #(.XLEN(32), .NREGS(32)) bus_a ();
    regfile_sb_if #(.XLEN(32), .NREGS(32)) bus_b ();

    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_b.rs1_addr = bus_a.rs1_addr;
    assign bus_b.rs2_addr = bus_a.rs2_addr;
    assign bus_b.wb_en    = bus_a.wb_en;
    assign bus_b.wb_addr  = bus_a.wb_addr;
    assign bus_b.wb_data  = bus_a.wb_data;
    assign bus_b.issue_en = bus_a.issue_en;
    assign bus_b.issue_rd = bus_a.issue_rd;
    assign bus_b.dbg_addr = bus_a.dbg_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.wb_en    = 1'b0;
        bus_a.wb_addr  = '0;
        bus_a.wb_data  = '0;
        bus_a.issue_en = 1'b0;
        bus_a.issue_rd = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus_a.rs1_addr = 5'd1;
        bus_a.rs2_addr = 5'd0;
        bus_a.dbg_addr = 5'd0;
        repeat (3) step();
        vectors++;
        if (bus_a.ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b want=0", bus_a.ready); end
        vectors++;
        if (bus_a.busy_vec !== 32'h0) begin miscompares++; $display("FAIL rst_busy_vec got=%h want=0", bus_a.busy_vec); end
        vectors++;
        if (bus_a.rs1_data !== 32'h0) begin miscompares++; $display("FAIL rst_rs1_data got=%h want=0", bus_a.rs1_data); end
        rst = 1'b0;
        bus_a.rs1_addr = 5'd2;
        bus_a.wb_en    = 1'b1;
        bus_a.wb_addr  = 5'd2;
        bus_a.wb_data  = 32'hFFFF_FFFF;
        bus_a.issue_en = 1'b1;
        bus_a.issue_rd = 5'd2;
        for (int i = 1; i <= 31; i++) begin
            step();
            if (i == 3) idle_inputs();
            vectors++;
            if (bus_a.ready !== (i == 31)) begin
                miscompares++;
                $display("FAIL clear_ready cycle=%0d got=%b want=%b", i, bus_a.ready, (i == 31));
            end
            if (i < 31) begin
                vectors++;
                if (bus_a.rs1_data !== 32'h0 || bus_a.rs1_busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL clear_read cycle=%0d got=%h/%b want=0/0", i, bus_a.rs1_data, bus_a.rs1_busy);
                end
            end
        end
        vectors++;
        if (bus_b.ready !== 1'b1) begin miscompares++; $display("FAIL clear_ready_b got=%b want=1", bus_b.ready); end
        vectors++;
        if (bus_a.busy_vec !== 32'h0) begin miscompares++; $display("FAIL clear_busy_vec got=%h want=0", bus_a.busy_vec); end
        vectors++;
        if (bus_a.rs1_data !== 32'h0) begin miscompares++; $display("FAIL clear_wb_ignored got=%h want=0", bus_a.rs1_data); end
        for (int a = 0; a < 32; a++) begin
            bus_a.dbg_addr = 5'(a);
            #1;
            vectors++;
            if (bus_a.dbg_data !== 32'h0) begin
                miscompares++;
                $display("FAIL clear_dbg addr=%0d got=%h want=0", a, bus_a.dbg_data);
            end
        end
    endtask

    task automatic test_bypass();
        step();
        bus_a.wb_en    = 1'b1;
        bus_a.wb_addr  = 5'd5;
        bus_a.wb_data  = 32'hDEAD_BEEF;
        bus_a.rs1_addr = 5'd5;
        #2;
        vectors++;
        if (bus_a.rs1_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL bypass_same got=%h want=deadbeef", bus_a.rs1_data); end
        vectors++;
        if (bus_b.rs1_data !== 32'h0) begin miscompares++; $display("FAIL nobypass_same got=%h want=0", bus_b.rs1_data); end
        step();
        idle_inputs();
        bus_a.dbg_addr = 5'd5;
        #2;
        vectors++;
        if (bus_a.rs1_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL bypass_next got=%h want=deadbeef", bus_a.rs1_data); end
        vectors++;
        if (bus_b.rs1_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL nobypass_next got=%h want=deadbeef", bus_b.rs1_data); end
        vectors++;
        if (bus_a.dbg_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL bypass_dbg got=%h want=deadbeef", bus_a.dbg_data); end
    endtask

    task automatic test_x0();
        step();
        bus_a.wb_en    = 1'b1;
        bus_a.wb_addr  = 5'd0;
        bus_a.wb_data  = 32'h0000_1234;
        bus_a.issue_en = 1'b1;
        bus_a.issue_rd = 5'd0;
        bus_a.rs1_addr = 5'd0;
        #2;
        vectors++;
        if (bus_a.rs1_data !== 32'h0) begin miscompares++; $display("FAIL x0_bypass got=%h want=0", bus_a.rs1_data); end
        step();
        idle_inputs();
        bus_a.dbg_addr = 5'd0;
        #2;
        vectors++;
        if (bus_a.rs1_data !== 32'h0 || bus_a.rs1_busy !== 1'b0) begin
            miscompares++; $display("FAIL x0_read got=%h/%b want=0/0", bus_a.rs1_data, bus_a.rs1_busy);
        end
        vectors++;
        if (bus_a.dbg_data !== 32'h0) begin miscompares++; $display("FAIL x0_dbg got=%h want=0", bus_a.dbg_data); end
        vectors++;
        if (bus_a.busy_vec !== 32'h0) begin miscompares++; $display("FAIL x0_busy_vec got=%h want=0", bus_a.busy_vec); end
    endtask

    task automatic test_scoreboard();
        step();
        bus_a.issue_en = 1'b1;
        bus_a.issue_rd = 5'd7;
        bus_a.rs2_addr = 5'd7;
        #2;
        vectors++;
        if (bus_a.rs2_busy !== 1'b0) begin miscompares++; $display("FAIL sb_pre_issue got=%b want=0", bus_a.rs2_busy); end
        step();
        idle_inputs();
        #2;
        vectors++;
        if (bus_a.rs2_busy !== 1'b1 || bus_b.rs2_busy !== 1'b1) begin
            miscompares++; $display("FAIL sb_issued got=%b/%b want=1/1", bus_a.rs2_busy, bus_b.rs2_busy);
        end
        step();
        bus_a.wb_en   = 1'b1;
        bus_a.wb_addr = 5'd7;
        bus_a.wb_data = 32'd9;
        #2;
        vectors++;
        if (bus_a.rs2_busy !== 1'b0 || bus_a.rs2_data !== 32'd9) begin
            miscompares++; $display("FAIL sb_wb_bypass got=%b/%h want=0/9", bus_a.rs2_busy, bus_a.rs2_data);
        end
        vectors++;
        if (bus_b.rs2_busy !== 1'b1) begin miscompares++; $display("FAIL sb_wb_nobypass got=%b want=1", bus_b.rs2_busy); end
        step();
        idle_inputs();
        #2;
        vectors++;
        if (bus_a.rs2_busy !== 1'b0 || bus_b.rs2_data !== 32'd9 || bus_b.busy_vec[7] !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_after_wb got=%b/%h/%b want=0/9/0", bus_a.rs2_busy, bus_b.rs2_data, bus_b.busy_vec[7]);
        end
    endtask

    task automatic test_same_cycle();
        step();
        bus_a.issue_en = 1'b1;
        bus_a.issue_rd = 5'd3;
        bus_a.wb_en    = 1'b1;
        bus_a.wb_addr  = 5'd3;
        bus_a.wb_data  = 32'd42;
        step();
        idle_inputs();
        bus_a.dbg_addr = 5'd3;
        #2;
        vectors++;
        if (bus_a.busy_vec !== 32'h0000_0008) begin miscompares++; $display("FAIL same_busy got=%h want=00000008", bus_a.busy_vec); end
        vectors++;
        if (bus_a.dbg_data !== 32'd42) begin miscompares++; $display("FAIL same_data got=%h want=0000002a", bus_a.dbg_data); end
        step();
        bus_a.issue_en = 1'b1;
        bus_a.issue_rd = 5'd3;
        step();
        idle_inputs();
        #2;
        vectors++;
        if (bus_a.busy_vec[3] !== 1'b1) begin miscompares++; $display("FAIL reissue_busy got=%b want=1", bus_a.busy_vec[3]); end
        step();
        bus_a.wb_en   = 1'b1;
        bus_a.wb_addr = 5'd3;
        bus_a.wb_data = 32'd43;
        step();
        idle_inputs();
        #2;
        vectors++;
        if (bus_a.busy_vec !== 32'h0 || bus_a.dbg_data !== 32'd43) begin
            miscompares++; $display("FAIL reissue_wb got=%h/%h want=0/0000002b", bus_a.busy_vec, bus_a.dbg_data);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        step();
        bus_a.wb_en   = 1'b1;
        bus_a.wb_addr = 5'd4;
        bus_a.wb_data = 32'd99;
        step();
        idle_inputs();
        bus_a.issue_en = 1'b1;
        bus_a.issue_rd = 5'd4;
        step();
        idle_inputs();
        bus_a.rs1_addr = 5'd4;
        bus_a.dbg_addr = 5'd4;
        #2;
        vectors++;
        if (bus_a.busy_vec !== 32'h0000_0010 || bus_a.dbg_data !== 32'd99) begin
            miscompares++; $display("FAIL pre_rst got=%h/%h want=00000010/00000063", bus_a.busy_vec, bus_a.dbg_data);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus_a.ready !== 1'b0 || bus_a.busy_vec !== 32'h0 || bus_b.busy_vec !== 32'h0) begin
            miscompares++;
            $display("FAIL async_rst got=%b/%h/%h want=0/0/0", bus_a.ready, bus_a.busy_vec, bus_b.busy_vec);
        end
        step();
        step();
        rst = 1'b0;
        n = 0;
        while (bus_a.ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (n !== 31) begin miscompares++; $display("FAIL rerun_ready_cycles got=%0d want=31", n); end
        #2;
        vectors++;
        if (bus_a.rs1_data !== 32'h0 || bus_a.rs1_busy !== 1'b0 || bus_a.dbg_data !== 32'h0 || bus_b.dbg_data !== 32'h0) begin
            miscompares++;
            $display("FAIL rerun_x4 got=%h/%b/%h/%h want=0/0/0/0",
                     bus_a.rs1_data, bus_a.rs1_busy, bus_a.dbg_data, bus_b.dbg_data);
        end
        vectors++;
        if (bus_a.busy_vec !== 32'h0) begin miscompares++; $display("FAIL rerun_busy_vec got=%h want=0", bus_a.busy_vec); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_same_cycle();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
